m6502_bus_ctrl: RTL and testbench
=================================

# m6502_bus_ctrl

Memory/bus controller directly downstream of the m6502 CPU core's external bus. Decodes each CPU access into on-chip RAM, boot ROM or the I/O peripheral port. Sequences wait states and drives `cpu_ready` and `cpu_rd_data` back to the core. Unanswered I/O accesses are bounded by a timeout and logged as bus errors.

## Interface
- `RAM_AW`, 15: RAM address width; RAM occupies `0x0000`..`2^RAM_AW-1`.
- `ROM_AW`, 12: ROM address width; ROM occupies `0x10000-2^ROM_AW`..`0xFFFF`.
- `IO_BASE`, 16'hD000: I/O window base; must be aligned to `2^IO_AW`.
- `IO_AW`, 8: I/O window address width.
- `IO_TIMEOUT`, 16: maximum cycles to wait for `io_ack`; valid range 2..255.

Ports:
- `clk` in 1: clock; all logic on rising edge.
- `reset_n` in 1: reset, synchronous, active-low.
- `cpu_addr` in 16: CPU address.
- `cpu_rd_req` in 1: read request, one-cycle pulse.
- `cpu_wr_en` in 1: write strobe, one-cycle pulse.
- `cpu_wr_data` in 8: write data.
- `cpu_rd_data` out 8: read data; valid while `cpu_ready`=1 after a read.
- `cpu_ready` out 1: 1 = idle/complete, 0 = access in progress.
- `ram_addr` out RAM_AW: RAM address.
- `ram_wr_en` out 1: RAM write strobe.
- `ram_wr_data` out 8: RAM write data.
- `ram_rd_data` in 8: RAM read data, 1-cycle synchronous latency.
- `rom_addr` out ROM_AW: ROM address.
- `rom_rd_data` in 8: ROM read data, 1-cycle latency.
- `io_addr` out IO_AW: I/O register offset.
- `io_rd_req` out 1: I/O read, held until ack or timeout.
- `io_wr_en` out 1: I/O write, held until ack or timeout.
- `io_wr_data` out 8: I/O write data.
- `io_rd_data` in 8: I/O read data, valid with `io_ack`.
- `io_ack` in 1: peripheral completion.
- `bus_err` out 1: sticky error flag; cleared only by reset.
- `bus_err_addr` out 16: address of the first error.

## Operation
- **Decode priority:** I/O window, then ROM, then RAM, else unmapped.
- **Request sampling:** a request is sampled only in IDLE. Requests arriving in any other state are ignored.
- **Simultaneous strobes:** if `cpu_rd_req` and `cpu_wr_en` are both 1, the write is performed, the read is dropped, and `bus_err` is set.
- **States:** IDLE, MEM_RD, IO_WAIT, DONE.
- **RAM/ROM read:** IDLE → MEM_RD, with address registered onto `ram_addr`/`rom_addr` and `cpu_ready`←0. MEM_RD → DONE, latching `ram_rd_data` or `rom_rd_data` into `cpu_rd_data`. DONE → IDLE with `cpu_ready`=1.
- **RAM write:** posted. `ram_wr_en` pulses 1 cycle, `cpu_ready` stays 1, state stays IDLE.
- **ROM write:** ignored silently; no error.
- **Unmapped read:** completes via DONE with data `8'hFF` and no error. Unmapped write is ignored.
- **I/O access:** IDLE → IO_WAIT; assert `io_rd_req`/`io_wr_en`, `cpu_ready`←0, cycle counter←0. The counter increments every cycle in IO_WAIT.
  - `io_ack`=1: deassert strobes, latch `io_rd_data` (reads only), → DONE.
  - Counter reaches `IO_TIMEOUT-1` without ack: deassert strobes, `cpu_rd_data`←`8'hFF`, set `bus_err`, capture `bus_err_addr` if not already set, → DONE.
  - `io_ack` arriving in the same cycle as the timeout wins: normal completion, no error.
- **Stray ack:** `io_ack` outside IO_WAIT is ignored.
- **Error capture:** `bus_err_addr` records only the first error.

## Timing
- **Reset values:** state IDLE, `cpu_ready`=1, `cpu_rd_data`=`8'h00`, every strobe 0, all address/data outputs 0, `bus_err`=0, `bus_err_addr`=0.
- **Reset mid-operation:** reset during IO_WAIT drops the I/O strobes in the next cycle and abandons the access.
- **Memory read latency:** request sampled at edge N; `cpu_ready`=0 after N; data valid and `cpu_ready`=1 after edge N+2.
- **I/O read latency:** ack sampled at edge M; data valid and `cpu_ready`=1 after edge M+1. Worst case is N+IO_TIMEOUT+1.
- **Ready pulse:** `cpu_ready` is low for at least one full cycle for every non-posted access. The CPU's "ready && !rd_req" qualification therefore never observes stale data.
- **Output holding:** `cpu_rd_data` holds its value until the next read completes.

## Structure
- **Shared package `m6502_bus_pkg`:** region constants (`REG_RAM`, `REG_ROM`, `REG_IO`, `REG_NONE`), state constants, and default map constants (`IO_BASE`, `ROM_AW`, `RAM_AW`).
- **Sub-module `m6502_addr_decode`:** combinational; 16-bit address → region code plus local offset, using the priority order above.
- **This block:** the FSM, the timeout counter, and the error registers.

## Test plan
1. Write `0x5A` to `0x0200` (`ram_wr_en` pulses 1 cycle, `cpu_ready` stays 1), then read `0x0200` → `cpu_ready` low 2 cycles, `cpu_rd_data`=`0x5A`.
2. Read `0xFFFC` with ROM word `0x34` → `rom_addr`=`0xFFC`, `cpu_rd_data`=`0x34` at N+2. A write to `0xFFFC` changes nothing.
3. Read `0xD010` with `io_ack` after 3 cycles and `io_rd_data`=`0xA7` → `io_addr`=`0x10`, `io_rd_req` held exactly 3 cycles, `cpu_rd_data`=`0xA7`, `bus_err`=0.
4. Write `0xD020` with no ack → `io_wr_en` held 16 cycles, `bus_err`=1, `bus_err_addr`=`0xD020`. A second timeout at `0xD030` leaves `bus_err_addr` at `0xD020`.
5. Read `0x8000` (unmapped) → `cpu_rd_data`=`0xFF`, `bus_err`=0. Simultaneous `cpu_rd_req`/`cpu_wr_en` to `0x0300` → RAM written, `bus_err`=1.
6. Assert `reset_n`=0 in the 5th cycle of IO_WAIT → next cycle strobes are 0, `cpu_ready`=1, `bus_err`=0. A following RAM read completes normally.

Source files
------------

// File: rtl/m6502_bus_ctrl_pkg.sv
// Shared definitions for the m6502 bus controller: region codes, FSM states
// and the default memory map.
package m6502_bus_pkg;

  typedef enum logic [1:0] {
    REG_RAM  = 2'd0,
    REG_ROM  = 2'd1,
    REG_IO   = 2'd2,
    REG_NONE = 2'd3
  } region_t;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_MEM_RD  = 2'd1,
    ST_IO_WAIT = 2'd2,
    ST_DONE    = 2'd3
  } state_t;

  localparam int          RAM_AW     = 15;
  localparam int          ROM_AW     = 12;
  localparam logic [15:0] IO_BASE    = 16'hD000;
  localparam int          IO_AW      = 8;
  localparam int          IO_TIMEOUT = 16;

endpackage

// File: rtl/m6502_bus_ctrl_if.sv
// CPU-side bus of the m6502 core: request strobes toward the controller,
// ready/read data back to the core.
interface m6502_bus_ctrl_if;
  logic [15:0] cpu_addr;
  logic        cpu_rd_req;
  logic        cpu_wr_en;
  logic [7:0]  cpu_wr_data;
  logic [7:0]  cpu_rd_data;
  logic        cpu_ready;

  modport master (
    output cpu_addr, cpu_rd_req, cpu_wr_en, cpu_wr_data,
    input  cpu_rd_data, cpu_ready
  );

  modport slave (
    input  cpu_addr, cpu_rd_req, cpu_wr_en, cpu_wr_data,
    output cpu_rd_data, cpu_ready
  );
endinterface

// File: rtl/m6502_bus_ctrl_addr_decode.sv
// Combinational address decode: I/O window beats ROM beats RAM, anything
// else is unmapped. Local offsets are plain low-order slices.
module m6502_addr_decode
  import m6502_bus_pkg::*;
#(
  parameter int          RAM_AW  = m6502_bus_pkg::RAM_AW,
  parameter int          ROM_AW  = m6502_bus_pkg::ROM_AW,
  parameter logic [15:0] IO_BASE = m6502_bus_pkg::IO_BASE,
  parameter int          IO_AW   = m6502_bus_pkg::IO_AW
) (
  input  logic [15:0]       addr,
  output region_t           region,
  output logic [RAM_AW-1:0] ram_off,
  output logic [ROM_AW-1:0] rom_off,
  output logic [IO_AW-1:0]  io_off
);

  assign ram_off = addr[RAM_AW-1:0];
  assign rom_off = addr[ROM_AW-1:0];
  assign io_off  = addr[IO_AW-1:0];

  always_comb begin
    region = REG_NONE;
    if (addr[15:IO_AW] == IO_BASE[15:IO_AW])
      region = REG_IO;
    else if (&addr[15:ROM_AW])
      region = REG_ROM;
    else if (addr[15:RAM_AW] == '0)
      region = REG_RAM;
  end

endmodule

// File: rtl/m6502_bus_ctrl.sv
// Bus controller between the m6502 core and RAM/ROM/I-O: wait-state FSM,
// I/O timeout counter and sticky bus-error capture.
//
//   state      | meaning
//   -----------+---------------------------------------------------------
//   ST_IDLE    | ready; samples cpu requests, RAM writes are posted here
//   ST_MEM_RD  | RAM/ROM address presented, memory producing data
//   ST_IO_WAIT | I/O strobe held, counting toward timeout
//   ST_DONE    | one-cycle completion, ready returns high on exit
module m6502_bus_ctrl
  import m6502_bus_pkg::*;
#(
  parameter int          RAM_AW     = m6502_bus_pkg::RAM_AW,
  parameter int          ROM_AW     = m6502_bus_pkg::ROM_AW,
  parameter logic [15:0] IO_BASE    = m6502_bus_pkg::IO_BASE,
  parameter int          IO_AW      = m6502_bus_pkg::IO_AW,
  parameter int          IO_TIMEOUT = m6502_bus_pkg::IO_TIMEOUT
) (
  input  logic              clk,
  input  logic              reset_n,
  m6502_bus_ctrl_if.slave   cpu,
  output logic [RAM_AW-1:0] ram_addr,
  output logic              ram_wr_en,
  output logic [7:0]        ram_wr_data,
  input  logic [7:0]        ram_rd_data,
  output logic [ROM_AW-1:0] rom_addr,
  input  logic [7:0]        rom_rd_data,
  output logic [IO_AW-1:0]  io_addr,
  output logic              io_rd_req,
  output logic              io_wr_en,
  output logic [7:0]        io_wr_data,
  input  logic [7:0]        io_rd_data,
  input  logic              io_ack,
  output logic              bus_err,
  output logic [15:0]       bus_err_addr
);

  localparam logic [7:0] IO_TC = 8'(IO_TIMEOUT - 1);

  state_t            state, state_nxt;
  region_t           region, rd_region;
  logic [RAM_AW-1:0] ram_off;
  logic [ROM_AW-1:0] rom_off;
  logic [IO_AW-1:0]  io_off;
  logic [7:0]        io_cnt;
  logic [15:0]       req_addr;
  logic [7:0]        rd_data_q;
  logic              ready_q;
  logic              wr, rd, conflict, io_tc;

  m6502_addr_decode #(
    .RAM_AW (RAM_AW),
    .ROM_AW (ROM_AW),
    .IO_BASE(IO_BASE),
    .IO_AW  (IO_AW)
  ) u_decode (
    .addr   (cpu.cpu_addr),
    .region (region),
    .ram_off(ram_off),
    .rom_off(rom_off),
    .io_off (io_off)
  );

  // A write always wins over a simultaneous read strobe.
  assign wr       = cpu.cpu_wr_en;
  assign rd       = cpu.cpu_rd_req & ~cpu.cpu_wr_en;
  assign conflict = cpu.cpu_rd_req & cpu.cpu_wr_en;
  assign io_tc    = (io_cnt == IO_TC);

  assign cpu.cpu_rd_data = rd_data_q;
  assign cpu.cpu_ready   = ready_q;

  always_ff @(posedge clk) begin
    if (!reset_n) state <= ST_IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (wr) begin
          if (region == REG_IO) state_nxt = ST_IO_WAIT;
        end else if (rd) begin
          case (region)
            REG_RAM, REG_ROM: state_nxt = ST_MEM_RD;
            REG_IO:           state_nxt = ST_IO_WAIT;
            default:          state_nxt = ST_DONE;
          endcase
        end
      end
      ST_MEM_RD:  state_nxt = ST_DONE;
      ST_IO_WAIT: if (io_ack || io_tc) state_nxt = ST_DONE;
      ST_DONE:    state_nxt = ST_IDLE;
      default:    state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      ram_addr     <= '0;
      ram_wr_en    <= 1'b0;
      ram_wr_data  <= '0;
      rom_addr     <= '0;
      io_addr      <= '0;
      io_rd_req    <= 1'b0;
      io_wr_en     <= 1'b0;
      io_wr_data   <= '0;
      io_cnt       <= '0;
      req_addr     <= '0;
      rd_region    <= REG_NONE;
      rd_data_q    <= 8'h00;
      ready_q      <= 1'b1;
      bus_err      <= 1'b0;
      bus_err_addr <= '0;
    end else begin
      ram_wr_en <= 1'b0;
      case (state)
        ST_IDLE: begin
          rd_region <= region;
          req_addr  <= cpu.cpu_addr;
          io_cnt    <= '0;
          if (conflict) begin
            bus_err <= 1'b1;
            if (!bus_err) bus_err_addr <= cpu.cpu_addr;
          end
          if (wr) begin
            if (region == REG_RAM) begin
              ram_addr    <= ram_off;
              ram_wr_data <= cpu.cpu_wr_data;
              ram_wr_en   <= 1'b1;
            end else if (region == REG_IO) begin
              io_addr    <= io_off;
              io_wr_data <= cpu.cpu_wr_data;
              io_wr_en   <= 1'b1;
              ready_q    <= 1'b0;
            end
          end else if (rd) begin
            ready_q <= 1'b0;
            case (region)
              REG_RAM: ram_addr <= ram_off;
              REG_ROM: rom_addr <= rom_off;
              REG_IO: begin
                io_addr   <= io_off;
                io_rd_req <= 1'b1;
              end
              default: rd_data_q <= 8'hFF;
            endcase
          end
        end
        ST_IO_WAIT: begin
          if (io_ack) begin
            io_rd_req <= 1'b0;
            io_wr_en  <= 1'b0;
            if (io_rd_req) rd_data_q <= io_rd_data;
          end else if (io_tc) begin
            io_rd_req <= 1'b0;
            io_wr_en  <= 1'b0;
            if (io_rd_req) rd_data_q <= 8'hFF;
            bus_err <= 1'b1;
            if (!bus_err) bus_err_addr <= req_addr;
          end else begin
            io_cnt <= io_cnt + 8'd1;
          end
        end
        ST_DONE: begin
          // Memory data is taken here so a registered-output RAM/ROM has settled.
          ready_q <= 1'b1;
          if (rd_region == REG_RAM)      rd_data_q <= ram_rd_data;
          else if (rd_region == REG_ROM) rd_data_q <= rom_rd_data;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_m6502_bus_ctrl.sv
// Randomised bench for m6502_bus_ctrl against a transaction-level model of
// the memory map, wait-state latencies and error capture.
module tb_m6502_bus_ctrl;

  localparam int IO_TIMEOUT = 16;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [14:0] ram_addr;
  logic        ram_wr_en;
  logic [7:0]  ram_wr_data;
  logic [7:0]  ram_rd_data;
  logic [11:0] rom_addr;
  logic [7:0]  rom_rd_data;
  logic [7:0]  io_addr;
  logic        io_rd_req;
  logic        io_wr_en;
  logic [7:0]  io_wr_data;
  logic [7:0]  io_rd_data;
  logic        io_ack;
  logic        bus_err;
  logic [15:0] bus_err_addr;

  m6502_bus_ctrl_if bus();

  m6502_bus_ctrl #(.IO_TIMEOUT(IO_TIMEOUT)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .cpu         (bus.slave),
    .ram_addr    (ram_addr),
    .ram_wr_en   (ram_wr_en),
    .ram_wr_data (ram_wr_data),
    .ram_rd_data (ram_rd_data),
    .rom_addr    (rom_addr),
    .rom_rd_data (rom_rd_data),
    .io_addr     (io_addr),
    .io_rd_req   (io_rd_req),
    .io_wr_en    (io_wr_en),
    .io_wr_data  (io_wr_data),
    .io_rd_data  (io_rd_data),
    .io_ack      (io_ack),
    .bus_err     (bus_err),
    .bus_err_addr(bus_err_addr)
  );

  always #5 clk = ~clk;

  // Memory devices the DUT talks to (registered read, one-cycle latency).
  bit [7:0] ram_dev [0:32767];
  bit [7:0] rom_dev [0:4095];

  always @(posedge clk) begin
    if (ram_wr_en) ram_dev[ram_addr] <= ram_wr_data;
    ram_rd_data <= ram_dev[ram_addr];
    rom_rd_data <= rom_dev[rom_addr];
  end

  // I/O peripheral: acks after ack_dly cycles of strobe, stray acks when idle.
  int       ack_dly;
  int       held;
  int       last_held;
  bit       stray_en;
  logic [7:0] io_last_data;

  always @(negedge clk) begin
    io_rd_data = 8'($urandom);
    if (io_rd_req || io_wr_en) begin
      held++;
      last_held = held;
      io_ack = (held == ack_dly);
      if (io_ack) io_last_data = io_rd_data;
    end else begin
      held = 0;
      io_ack = stray_en && ($urandom_range(0, 3) == 0);
    end
  end

  // Reference model state
  bit [7:0]    m_ram [0:32767];
  logic [7:0]  m_rd;
  logic        m_err;
  logic [15:0] m_err_addr;

  int n_chk = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // 0 RAM, 1 ROM, 2 I/O, 3 unmapped
  function automatic int region_of(input logic [15:0] a);
    if (a >= 16'hD000 && a <= 16'hD0FF) return 2;
    if (a >= 16'hF000)                  return 1;
    if (a < 16'h8000)                   return 0;
    return 3;
  endfunction

  function automatic void model_err(input logic [15:0] a);
    if (!m_err) m_err_addr = a;
    m_err = 1'b1;
  endfunction

  task automatic xact(input logic [15:0] a, input bit rd, input bit wr,
                      input logic [7:0] d, input int dly);
    int  rc, exp_low, low;
    bit  is_rd, io, tmo;
    rc    = region_of(a);
    is_rd = rd && !wr;
    io    = (rc == 2) && (rd || wr);
    tmo   = io && (dly > IO_TIMEOUT);
    ack_dly = dly;

    @(negedge clk);
    check("ram_wr_pulse", 32'(ram_wr_en), 32'd0);
    bus.cpu_addr    = a;
    bus.cpu_rd_req  = rd;
    bus.cpu_wr_en   = wr;
    bus.cpu_wr_data = d;
    @(negedge clk);
    bus.cpu_rd_req = 1'b0;
    bus.cpu_wr_en  = 1'b0;

    if (wr && rc == 0) begin
      check("ram_wr_en", 32'(ram_wr_en), 32'd1);
      check("ram_wr_addr", 32'(ram_addr), 32'(a[14:0]));
      check("ram_wr_data", 32'(ram_wr_data), 32'(d));
    end

    low = 0;
    while (!bus.cpu_ready && low < 64) begin
      low++;
      @(negedge clk);
    end

    if (io)              exp_low = tmo ? IO_TIMEOUT + 1 : dly + 1;
    else if (is_rd)      exp_low = (rc <= 1) ? 2 : 1;
    else                 exp_low = 0;
    check("ready_low", 32'(low), 32'(exp_low));

    if (rd && wr) model_err(a);
    if (wr && rc == 0) m_ram[a[14:0]] = d;
    if (is_rd) begin
      case (rc)
        0:       m_rd = m_ram[a[14:0]];
        1:       m_rd = rom_dev[a[11:0]];
        2:       m_rd = tmo ? 8'hFF : io_last_data;
        default: m_rd = 8'hFF;
      endcase
    end
    if (tmo) model_err(a);

    check("rd_data", 32'(bus.cpu_rd_data), 32'(m_rd));
    check("bus_err", 32'(bus_err), 32'(m_err));
    check("bus_err_addr", 32'(bus_err_addr), 32'(m_err_addr));
    if (io) begin
      check("io_held", 32'(last_held), 32'(tmo ? IO_TIMEOUT : dly));
      check("io_addr", 32'(io_addr), 32'(a[7:0]));
      check("io_strobe_off", 32'({io_rd_req, io_wr_en}), 32'd0);
    end
    if (is_rd && rc == 0) check("ram_rd_addr", 32'(ram_addr), 32'(a[14:0]));
    if (is_rd && rc == 1) check("rom_addr", 32'(rom_addr), 32'(a[11:0]));
  endtask

  initial begin
    logic [15:0] a;
    int k, op;

    for (int i = 0; i < 4096; i++) rom_dev[i] = 8'($urandom);
    rom_dev[12'hFFC] = 8'h34;
    bus.cpu_addr = '0; bus.cpu_rd_req = 0; bus.cpu_wr_en = 0; bus.cpu_wr_data = '0;
    ack_dly = 0; held = 0; last_held = 0; stray_en = 0; io_last_data = '0;
    io_ack = 0; io_rd_data = '0;
    m_rd = 8'h00; m_err = 0; m_err_addr = '0;

    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_ready", 32'(bus.cpu_ready), 32'd1);
    check("rst_rd_data", 32'(bus.cpu_rd_data), 32'd0);
    check("rst_strobes", 32'({ram_wr_en, io_rd_req, io_wr_en}), 32'd0);
    check("rst_addrs", 32'(ram_addr) | 32'(rom_addr) | 32'(io_addr), 32'd0);
    check("rst_wdata", 32'({ram_wr_data, io_wr_data}), 32'd0);
    check("rst_err", 32'({bus_err, bus_err_addr}), 32'd0);
    reset_n = 1'b1;
    stray_en = 1'b1;

    xact(16'h0200, 0, 1, 8'h5A, 0);
    xact(16'h0200, 1, 0, 8'h00, 0);
    xact(16'hFFFC, 1, 0, 8'h00, 0);
    xact(16'hFFFC, 0, 1, 8'h99, 0);
    xact(16'hFFFC, 1, 0, 8'h00, 0);
    xact(16'hD010, 1, 0, 8'h00, 3);
    xact(16'hD020, 0, 1, 8'h11, 99);
    xact(16'hD030, 0, 1, 8'h22, 99);
    xact(16'h8000, 1, 0, 8'h00, 0);
    xact(16'h0300, 1, 1, 8'h77, 0);
    xact(16'h0300, 1, 0, 8'h00, 0);
    xact(16'hD0FF, 1, 0, 8'h00, IO_TIMEOUT);
    xact(16'hD001, 1, 0, 8'h00, IO_TIMEOUT + 1);
    xact(16'hD002, 1, 0, 8'h00, 1);
    xact(16'hD100, 1, 0, 8'h00, 0);

    // Reset in the 5th cycle of an unanswered I/O read.
    ack_dly = 999;
    @(negedge clk);
    bus.cpu_addr = 16'hD040; bus.cpu_rd_req = 1'b1;
    @(negedge clk);
    bus.cpu_rd_req = 1'b0;
    repeat (4) @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    check("midrst_strobes", 32'({io_rd_req, io_wr_en}), 32'd0);
    check("midrst_ready", 32'(bus.cpu_ready), 32'd1);
    check("midrst_err", 32'(bus_err), 32'd0);
    m_err = 0; m_err_addr = '0; m_rd = 8'h00;
    xact(16'h0200, 1, 0, 8'h00, 0);

    for (int i = 0; i < 250; i++) begin
      k  = $urandom_range(0, 3);
      op = $urandom_range(0, 9);
      case (k)
        0:       a = 16'h0200 + 16'($urandom_range(0, 31));
        1:       a = 16'hF000 + 16'($urandom_range(0, 4095));
        2:       a = 16'hD000 + 16'($urandom_range(0, 255));
        default: a = 16'h8000 + 16'($urandom_range(0, 16'h4FFF));
      endcase
      xact(a, op <= 4 || op == 9, op >= 5, 8'($urandom), $urandom_range(1, 18));
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
